// File: rtl/em4100_pkg.sv
// em4100_pkg
// Shared constants and types for the EM4100 transmit encoder.
//   FRAME_BITS  : bits in one EM4100 frame
//   HEADER_BITS : leading 1s that open every frame
//   DATA_ROWS   : nibble rows, each followed by its row parity bit
//   ID_BITS     : width of the tag ID
//   state_t     : transmit FSM states
package em4100_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int HEADER_BITS = 9;
  localparam int DATA_ROWS   = 10;
  localparam int ID_BITS     = 40;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/em4100_frame_builder.sv
// em4100_frame_builder
// Purely combinational assembly of the 64-bit EM4100 frame from a 40-bit ID.
// Ports:
//   id    : tag ID, id[39] is the first data bit on air
//   frame : assembled frame; frame[63] is transmitted first, frame[0] last
module em4100_frame_builder
  import em4100_pkg::*;
(
  input  logic [ID_BITS-1:0]    id,
  output logic [FRAME_BITS-1:0] frame
);

  logic [3:0] nib;
  logic [3:0] colpar;

  // Frame layout from the top down: header of 1s, ten nibble rows each
  // followed by even row parity, the column parity nibble, then the stop bit
  // left at 0 by the default. Column parity is the running XOR of all nibbles,
  // so its MSB naturally pairs with the nibble MSBs and is sent first.
  always_comb begin
    frame  = '0;
    nib    = '0;
    colpar = '0;
    frame[FRAME_BITS-1 -: HEADER_BITS] = '1;
    for (int r = 0; r < DATA_ROWS; r++) begin
      nib = id[ID_BITS-1-4*r -: 4];
      frame[FRAME_BITS-1-HEADER_BITS-5*r -: 4] = nib;
      frame[FRAME_BITS-1-HEADER_BITS-5*r-4]    = ^nib;
      colpar = colpar ^ nib;
    end
    frame[FRAME_BITS-1-HEADER_BITS-5*DATA_ROWS -: 4] = colpar;
  end

endmodule

// File: rtl/em4100.sv
// em4100
// EM4100 transmit encoder: latches a tag ID at each frame start and streams
// the Manchester-encoded 64-bit frame, repeating while tx stays high.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, aborts any frame in flight
//   tx   : transmit enable, only looked at on frame boundaries
//   data : 40-bit tag ID, captured at frame start
//   q    : registered Manchester output (first half ~bit, second half bit)
module em4100
  import em4100_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx,
  input  logic [ID_BITS-1:0] data,
  output logic               q
);

  localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [5:0]    LAST_BIT = 6'(FRAME_BITS - 1);

  state_t                state, state_n;
  logic [5:0]            bit_idx, bit_idx_n;
  logic                  half, half_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  load;
  logic                  q_n;
  logic                  cur_bit;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [FRAME_BITS-1:0] built;

  em4100_frame_builder u_builder (
    .id    (data),
    .frame (built)
  );

  assign cur_bit = frame_reg[LAST_BIT - bit_idx];

  // State, counters, frame register and output register. q is registered
  // from the current position, so it trails the counters by one cycle: the
  // first half-bit appears one edge after the frame is latched, and the
  // final half-bit is still held for the edge on which the FSM decides to
  // restart or go idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      half      <= 1'b0;
      cnt       <= '0;
      q         <= 1'b0;
      frame_reg <= '0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      half    <= half_n;
      cnt     <= cnt_n;
      q       <= q_n;
      if (load) begin
        frame_reg <= built;
      end
    end
  end

  // Next-state logic. The cycle counter paces each half-bit; on the last
  // cycle of the second half of the stop bit, tx decides between reloading
  // a fresh frame with no gap or dropping back to IDLE. A frame is never
  // cut short by tx going low.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    half_n    = half;
    cnt_n     = cnt;
    load      = 1'b0;
    q_n       = 1'b0;
    case (state)
      IDLE: begin
        if (tx) begin
          state_n   = SEND;
          bit_idx_n = '0;
          half_n    = 1'b0;
          cnt_n     = '0;
          load      = 1'b1;
        end
      end
      SEND: begin
        q_n = half ? cur_bit : ~cur_bit;
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (!half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (bit_idx == LAST_BIT) begin
              bit_idx_n = '0;
              if (tx) begin
                load = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end else begin
              bit_idx_n = bit_idx + 6'd1;
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_em4100.sv
// tb_em4100
// Self-checking bench for the EM4100 encoder. Two instances share clock and
// reset: one at one cycle per half-bit, one at the RF/64 rate of 32.
module tb_em4100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx1 = 1'b0;
  logic        tx32 = 1'b0;
  logic [39:0] data1 = '0;
  logic [39:0] data32 = '0;
  logic        q1;
  logic        q32;

  int tests = 0;
  int fails = 0;
  bit cap[$];

  em4100 #(.HALF_BIT_CYCLES(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .tx   (tx1),
    .data (data1),
    .q    (q1)
  );

  em4100 #(.HALF_BIT_CYCLES(32)) dut32 (
    .clk  (clk),
    .rst  (rst),
    .tx   (tx32),
    .data (data32),
    .q    (q32)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference frame in transmission order: f[0] is sent first.
  function automatic logic [63:0] model_frame(input logic [39:0] id);
    logic [63:0] f;
    int nib;
    int ones;
    int cp[4];
    f = '0;
    for (int k = 0; k < 4; k++) cp[k] = 0;
    for (int i = 0; i < 9; i++) f[i] = 1'b1;
    for (int r = 0; r < 10; r++) begin
      nib = int'((id >> (36 - 4*r)) & 40'hF);
      ones = 0;
      for (int j = 0; j < 4; j++) begin
        f[9 + 5*r + j] = ((nib >> (3 - j)) & 1) != 0;
        ones += (nib >> j) & 1;
      end
      f[13 + 5*r] = (ones % 2) == 1;
      for (int k = 0; k < 4; k++) cp[k] += (nib >> k) & 1;
    end
    for (int k = 0; k < 4; k++) f[62 - k] = (cp[k] % 2) == 1;
    f[63] = 1'b0;
    return f;
  endfunction

  // Half-bit sequence for one frame: w[2i] = ~bit, w[2i+1] = bit.
  function automatic logic [127:0] wave(input logic [63:0] f);
    logic [127:0] w;
    for (int i = 0; i < 64; i++) begin
      w[2*i]   = ~f[i];
      w[2*i+1] = f[i];
    end
    return w;
  endfunction

  function automatic logic [127:0] grab(input int base);
    logic [127:0] g;
    for (int s = 0; s < 128; s++) g[s] = cap[base + s];
    return g;
  endfunction

  function automatic logic [39:0] rand_id();
    logic [39:0] v;
    v = {8'($urandom_range(0, 255)), 32'($urandom())};
    return v;
  endfunction

  task automatic doReset();
    @(negedge clk);
    tx1  = 1'b0;
    tx32 = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with tx already high: passes the sampling edge and
  // the edge before the first half-bit appears on q.
  task automatic beginFrame();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Records n consecutive q samples, optionally dropping tx or changing data1
  // right after a given sample.
  task automatic applyStimulus(input int which, input int n, input int dropAt,
                               input int chgAt, input logic [39:0] newData);
    cap.delete();
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      cap.push_back(which == 0 ? q1 : q32);
      if (s == dropAt) begin
        if (which == 0) tx1 = 1'b0;
        else tx32 = 1'b0;
      end
      if (s == chgAt) data1 = newData;
    end
  endtask

  task automatic test_reset();
    logic [39:0] id;
    logic [127:0] got, exp;
    int guard;
    doReset();
    tests++;
    if (q1 !== 1'b0 || q32 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle: q1=%b q32=%b, required 0 0", q1, q32);
    end
    id = rand_id();
    data1 = id;
    tx1 = 1'b1;
    beginFrame();
    applyStimulus(0, 37, -1, -1, '0);
    guard = 0;
    while (q1 !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (q1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: q=%b right after rst, required 0", q1);
    end
    @(negedge clk);
    rst = 1'b0;
    beginFrame();
    applyStimulus(0, 128, -1, -1, '0);
    got = grab(0);
    exp = wave(model_frame(id));
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL reset_restart: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_pattern55();
    logic [127:0] exp, got;
    int p;
    doReset();
    data1 = 40'h5555555555;
    repeat (4) @(negedge clk);
    tx1 = 1'b1;
    beginFrame();
    applyStimulus(0, 384, -1, -1, '0);
    exp = '0;
    p = 0;
    for (int i = 0; i < 9; i++) begin exp[p] = 0; exp[p+1] = 1; p += 2; end
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 5; j++) begin
        exp[p]   = (j % 2 == 0);
        exp[p+1] = (j % 2 != 0);
        p += 2;
      end
    end
    for (int i = 0; i < 5; i++) begin exp[p] = 1; exp[p+1] = 0; p += 2; end
    for (int k = 0; k < 3; k++) begin
      got = grab(128 * k);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL pattern55_frame%0d: got %h, required %h", k, got, exp);
      end
    end
  endtask

  task automatic test_known_id();
    logic [39:0] id, dec;
    logic [63:0] d;
    logic [9:0] rp;
    logic [3:0] cp;
    logic [127:0] got, exp;
    doReset();
    id = 40'h06001259E3;
    data1 = id;
    tx1 = 1'b1;
    beginFrame();
    applyStimulus(0, 128, 0, -1, '0);
    got = grab(0);
    exp = wave(model_frame(id));
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL known_wave: got %h, required %h", got, exp);
    end
    for (int i = 0; i < 64; i++) d[i] = cap[2*i+1];
    dec = '0;
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 4; j++) dec = {dec[38:0], d[9 + 5*r + j]};
      rp[9 - r] = d[13 + 5*r];
    end
    cp = {d[59], d[60], d[61], d[62]};
    tests++;
    if (d[8:0] !== 9'h1FF || d[63] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL known_header_stop: header=%b stop=%b, required 111111111 0", d[8:0], d[63]);
    end
    tests++;
    if (rp !== 10'b0000110010) begin
      fails++;
      $display("[TB] FAIL known_rowpar: got %b, required 0000110010", rp);
    end
    tests++;
    if (cp !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL known_colpar: got %b, required 0100", cp);
    end
    tests++;
    if (dec !== id) begin
      fails++;
      $display("[TB] FAIL known_decode: got %h, required %h", dec, id);
    end
  endtask

  task automatic test_tx_drop();
    logic [39:0] id;
    logic [127:0] got, exp;
    logic [19:0] tail;
    doReset();
    id = rand_id();
    data1 = id;
    tx1 = 1'b1;
    beginFrame();
    applyStimulus(0, 148, 50, -1, '0);
    got = grab(0);
    exp = wave(model_frame(id));
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL drop_frame: got %h, required %h", got, exp);
    end
    for (int s = 0; s < 20; s++) tail[s] = cap[128 + s];
    tests++;
    if (tail !== 20'h0) begin
      fails++;
      $display("[TB] FAIL drop_idle: got %h, required 00000", tail);
    end
  endtask

  task automatic test_data_change();
    logic [39:0] a, b;
    logic [127:0] got, exp;
    doReset();
    a = rand_id();
    b = ~a;
    data1 = a;
    tx1 = 1'b1;
    beginFrame();
    applyStimulus(0, 256, -1, 60, b);
    for (int k = 0; k < 2; k++) begin
      got = grab(128 * k);
      exp = wave(model_frame(k == 0 ? a : b));
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL datachg_frame%0d: got %h, required %h", k, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] ids[5];
    logic [127:0] got, exp;
    int chg;
    doReset();
    ids[0] = rand_id();
    data1 = ids[0];
    tx1 = 1'b1;
    beginFrame();
    cap.delete();
    for (int k = 0; k < 4; k++) begin
      chg = $urandom_range(10, 110);
      ids[k+1] = rand_id();
      for (int s = 0; s < 128; s++) begin
        @(negedge clk);
        cap.push_back(q1);
        if (s == chg) data1 = ids[k+1];
      end
    end
    for (int k = 0; k < 4; k++) begin
      got = grab(128 * k);
      exp = wave(model_frame(ids[k]));
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL b2b_frame%0d: got %h, required %h", k, got, exp);
      end
    end
  endtask

  task automatic test_slow();
    logic [39:0] id;
    logic [127:0] got, exp;
    logic [63:0] d;
    logic [9:0] rp;
    logic [3:0] cp;
    logic [7:0] tail;
    int unstable;
    doReset();
    id = 40'hFFFFFFFFFF;
    data32 = id;
    tx32 = 1'b1;
    beginFrame();
    applyStimulus(1, 4096 + 8, 100, -1, '0);
    unstable = 0;
    for (int h = 0; h < 128; h++) begin
      got[h] = cap[32*h];
      for (int s = 1; s < 32; s++) begin
        if (cap[32*h + s] != cap[32*h]) unstable++;
      end
    end
    exp = wave(model_frame(id));
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL slow_wave: got %h, required %h", got, exp);
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("[TB] FAIL slow_halfbit_hold: %0d samples changed inside a half-bit, required 0", unstable);
    end
    for (int i = 0; i < 64; i++) d[i] = got[2*i+1];
    for (int r = 0; r < 10; r++) rp[9 - r] = d[13 + 5*r];
    cp = {d[59], d[60], d[61], d[62]};
    tests++;
    if (rp !== 10'b0 || cp !== 4'b0) begin
      fails++;
      $display("[TB] FAIL slow_parity: row=%b col=%b, required all 0", rp, cp);
    end
    for (int s = 0; s < 8; s++) tail[s] = cap[4096 + s];
    tests++;
    if (tail !== 8'h0) begin
      fails++;
      $display("[TB] FAIL slow_frame_len: q after 4096 cycles %b, required 00000000", tail);
    end
  endtask

  initial begin
    test_reset();
    test_pattern55();
    test_known_id();
    test_tx_drop();
    test_data_change();
    test_back_to_back();
    test_slow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
